// File: rtl/pc_sequencer_if.sv
// Interface carrying the sequencer's control inputs and its PC / stack-status outputs.
// The master drives the requests (decode side); the slave is the sequencer itself.
interface pc_sequencer_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int STACK_DEPTH   = 4
);
  localparam int COUNT_WIDTH = $clog2(STACK_DEPTH + 1);

  logic                     advance;
  logic                     bra_valid;
  logic [ADDRESS_WIDTH-1:0] bra_target;
  logic                     call_valid;
  logic [ADDRESS_WIDTH-1:0] call_target;
  logic                     ret_valid;
  logic                     err_clr;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [COUNT_WIDTH-1:0]   stack_count;
  logic                     stack_full;
  logic                     stack_empty;
  logic                     ovf_err;
  logic                     unf_err;

  modport master (
    output advance, bra_valid, bra_target, call_valid, call_target, ret_valid, err_clr,
    input  pc, stack_count, stack_full, stack_empty, ovf_err, unf_err
  );

  modport slave (
    input  advance, bra_valid, bra_target, call_valid, call_target, ret_valid, err_clr,
    output pc, stack_count, stack_full, stack_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with sequential advance, branch, call/return through a return-address stack,
// stall and sticky stack-error flags. Define PC_TRAP_EN to redirect the PC to TRAP_VECTOR on
// stack overflow/underflow; otherwise an erroneous call/return behaves as a plain increment.
module pc_sequencer #(
  parameter int                     ADDRESS_WIDTH = 12,
  parameter int                     STACK_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDRESS_WIDTH-1:0] TRAP_VECTOR  = {ADDRESS_WIDTH{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);

  localparam int COUNT_WIDTH = $clog2(STACK_DEPTH + 1);
  localparam int INDEX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic [ADDRESS_WIDTH-1:0] ras_q [STACK_DEPTH];
  logic [ADDRESS_WIDTH-1:0] ras_d [STACK_DEPTH];

  logic [ADDRESS_WIDTH-1:0] pc_inc;
  logic [ADDRESS_WIDTH-1:0] err_pc;
  logic [INDEX_WIDTH-1:0]   push_idx;
  logic [INDEX_WIDTH-1:0]   pop_idx;
  logic                     full;
  logic                     empty;
  logic                     ovf_set;
  logic                     unf_set;

  // Status decodes come from registered state only, never from the request inputs.
  assign full     = (count_q == COUNT_WIDTH'(STACK_DEPTH));
  assign empty    = (count_q == '0);
  assign pc_inc   = pc_q + ADDRESS_WIDTH'(1);
  assign err_pc   = TRAP_EN ? TRAP_VECTOR : pc_inc;
  assign push_idx = INDEX_WIDTH'(count_q);
  assign pop_idx  = INDEX_WIDTH'(count_q - COUNT_WIDTH'(1));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    pc_d    = pc_q;
    count_d = count_q;
    ras_d   = ras_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (bus.advance) begin
      if (bus.ret_valid) begin
        if (empty) begin
          unf_set = 1'b1;
          pc_d    = err_pc;
        end else begin
          pc_d    = ras_q[pop_idx];
          count_d = count_q - COUNT_WIDTH'(1);
        end
      end else if (bus.call_valid) begin
        if (full) begin
          ovf_set = 1'b1;
          pc_d    = err_pc;
        end else begin
          ras_d[push_idx] = pc_inc;
          count_d         = count_q + COUNT_WIDTH'(1);
          pc_d            = bus.call_target;
        end
      end else if (bus.bra_valid) begin
        pc_d = bus.bra_target;
      end else begin
        pc_d = pc_inc;
      end
    end

    // Clear applies even during a stall; a fresh error in the same cycle keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
    unf_d = unf_set | (unf_q & ~bus.err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the stack storage is deliberately not reset; entries are only read below count_q,
  // which reset already zeroes, so stale contents are unreachable.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.pc          = pc_q;
  assign bus.stack_count = count_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;

endmodule
